jelly2_ram_sdp_byteen: RTL and testbench

- Single-clock simple dual-port RAM (one write port, one read port) with per-lane byte-enable writes.
- Selectable read-during-write behaviour; a read-valid pipeline tracks latency so consumers need no external delay counter.
- Optional output register stage with clock enable.
- Next-generation building block for line buffers, LUT tables and FIFO cores in the jelly2 library.

---
 rtl/jelly2_ram_pkg.sv | 38 +++
 rtl/jelly2_ram_dout_stage.sv | 43 ++++
 rtl/jelly2_ram_sdp_byteen.sv | 118 +++++++++++
 tb/tb_jelly2_ram_sdp_byteen.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/jelly2_ram_pkg.sv
// Shared definitions for the jelly2 RAM family: read-during-write mode names
// and the byte-lane merge used by every byte-enable memory.
package jelly2_ram_pkg;

  localparam string RDW_WRITE_FIRST = "WRITE_FIRST";
  localparam string RDW_READ_FIRST  = "READ_FIRST";

  // Widest configuration merge_lanes can serve; callers cast into and out of it.
  localparam int RAM_MAX_WE_W   = 64;
  localparam int RAM_MAX_DATA_W = 1024;

  typedef logic [RAM_MAX_DATA_W-1:0] ram_word_t;
  typedef logic [RAM_MAX_WE_W-1:0]   ram_we_t;

  // Lanes with we[i]=1 take new_data, all others keep old_data.
  function automatic ram_word_t merge_lanes(
    input ram_word_t old_data,
    input ram_word_t new_data,
    input ram_we_t   we,
    input int        we_width,
    input int        word_width
  );
    ram_word_t lane_ones;
    ram_word_t mask;
    ram_we_t   we_sh;
    lane_ones = (ram_word_t'(1) << word_width) - ram_word_t'(1);
    mask      = '0;
    we_sh     = we;
    for (int i = 0; i < RAM_MAX_WE_W; i++) begin
      if (i < we_width && we_sh[0]) begin
        mask = mask | (lane_ones << (i * word_width));
      end
      we_sh = we_sh >> 1;
    end
    return (old_data & ~mask) | (new_data & mask);
  endfunction

endpackage

// File: rtl/jelly2_ram_dout_stage.sv
// Optional output register with its valid flag; a pass-through when DOUT_REGS=0.
// Shared by the jelly2 RAM and FIFO variants.
module jelly2_ram_dout_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int DOUT_REGS  = 1
)(
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cke,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  din_valid,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid
);

  if (DOUT_REGS != 0) begin : g_reg
    logic [DATA_WIDTH-1:0] dout_p2;
    logic                  vld_p2;

    // ---- stage 2: output register, loads only on a valid stage-1 word ----
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        dout_p2 <= '0;
        vld_p2  <= 1'b0;
      end else if (cke) begin
        vld_p2 <= din_valid;
        if (din_valid) begin
          dout_p2 <= din;
        end
      end
    end

    assign dout       = dout_p2;
    assign dout_valid = vld_p2;
  end else begin : g_bypass
    logic unused_ctl;
    assign unused_ctl = ^{clk, reset_n, cke};

    assign dout       = din;
    assign dout_valid = din_valid;
  end

endmodule

// File: rtl/jelly2_ram_sdp_byteen.sv
// Simple dual-port RAM (one write, one read port) with per-lane byte enables,
// selectable read-during-write result and a latency-tracking read valid.
module jelly2_ram_sdp_byteen
  import jelly2_ram_pkg::*;
#(
  parameter int                       ADDR_WIDTH   = 10,
  parameter int                       WE_WIDTH     = 4,
  parameter int                       WORD_WIDTH   = 8,
  parameter int                       DATA_WIDTH   = WE_WIDTH * WORD_WIDTH,
  parameter int                       MEM_SIZE     = 1 << ADDR_WIDTH,
  parameter string                    RAM_TYPE     = "block",
  parameter int                       DOUT_REGS    = 1,
  parameter string                    RDW_MODE     = RDW_WRITE_FIRST,
  parameter int                       FILLMEM      = 0,
  parameter logic [DATA_WIDTH-1:0]    FILLMEM_DATA = '0
)(
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cke,

  input  logic                  wr_en,
  input  logic [WE_WIDTH-1:0]   wr_we,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_din,

  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_dout,
  output logic                  rd_valid
);

  localparam bit RDW_WF = (RDW_MODE == RDW_WRITE_FIRST);

  // ---- elaboration-time parameter checks ----
  if (RDW_MODE != RDW_WRITE_FIRST && RDW_MODE != RDW_READ_FIRST) begin : g_chk_rdw
    $error("jelly2_ram_sdp_byteen: RDW_MODE must be WRITE_FIRST or READ_FIRST");
  end
  if (DOUT_REGS != 0 && DOUT_REGS != 1) begin : g_chk_dout
    $error("jelly2_ram_sdp_byteen: DOUT_REGS must be 0 or 1");
  end
  if (DATA_WIDTH != WE_WIDTH * WORD_WIDTH) begin : g_chk_width
    $error("jelly2_ram_sdp_byteen: DATA_WIDTH is derived and must equal WE_WIDTH*WORD_WIDTH");
  end
  if (MEM_SIZE < 1 || MEM_SIZE > (1 << ADDR_WIDTH)) begin : g_chk_size
    $error("jelly2_ram_sdp_byteen: MEM_SIZE must be in 1..(1<<ADDR_WIDTH)");
  end
  if (WE_WIDTH > RAM_MAX_WE_W || DATA_WIDTH > RAM_MAX_DATA_W) begin : g_chk_max
    $error("jelly2_ram_sdp_byteen: word wider than merge_lanes supports");
  end

  // Both branches name the array g_mem.mem so the ports below stay mode-agnostic.
  if (FILLMEM != 0) begin : g_mem
    (* ram_style = RAM_TYPE *)
    logic [DATA_WIDTH-1:0] mem [0:MEM_SIZE-1] = '{default: FILLMEM_DATA};
  end else begin : g_mem
    (* ram_style = RAM_TYPE *)
    logic [DATA_WIDTH-1:0] mem [0:MEM_SIZE-1];
  end

  logic                  wr_in_range;
  logic                  rd_in_range;
  logic                  rdw_hit;
  logic [DATA_WIDTH-1:0] wr_merged;
  logic [DATA_WIDTH-1:0] rd_old;
  logic [DATA_WIDTH-1:0] rd_word;

  assign wr_in_range = int'(wr_addr) < MEM_SIZE;
  assign rd_in_range = int'(rd_addr) < MEM_SIZE;
  assign rdw_hit     = wr_en && wr_in_range && (wr_addr == rd_addr);

  always_comb begin
    wr_merged = DATA_WIDTH'(merge_lanes(ram_word_t'(g_mem.mem[wr_addr]),
                                        ram_word_t'(wr_din),
                                        ram_we_t'(wr_we),
                                        WE_WIDTH, WORD_WIDTH));
    rd_old    = rd_in_range ? g_mem.mem[rd_addr] : '0;
    // On a same-address hit the write word already holds old lanes plus the new ones.
    rd_word   = (RDW_WF && rdw_hit) ? wr_merged : rd_old;
  end

  // ---- write port: out-of-range addresses are dropped ----
  always_ff @(posedge clk) begin
    if (cke && wr_en && wr_in_range) begin
      g_mem.mem[wr_addr] <= wr_merged;
    end
  end

  logic [DATA_WIDTH-1:0] dout_p1;
  logic                  vld_p1;

  // ---- stage 1: memory read register ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dout_p1 <= '0;
      vld_p1  <= 1'b0;
    end else if (cke) begin
      vld_p1 <= rd_en;
      if (rd_en) begin
        dout_p1 <= rd_word;
      end
    end
  end

  // ---- stage 2: optional output register ----
  jelly2_ram_dout_stage #(
    .DATA_WIDTH (DATA_WIDTH),
    .DOUT_REGS  (DOUT_REGS)
  ) u_dout_stage (
    .clk        (clk),
    .reset_n    (reset_n),
    .cke        (cke),
    .din        (dout_p1),
    .din_valid  (vld_p1),
    .dout       (rd_dout),
    .dout_valid (rd_valid)
  );

endmodule

// File: tb/tb_jelly2_ram_sdp_byteen.sv
// Directed bench: a WRITE_FIRST and a READ_FIRST instance share every input,
// both with MEM_SIZE=1000 so the out-of-range window 1000..1023 exists.
module tb_jelly2_ram_sdp_byteen;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cke;
  logic        wr_en;
  logic [3:0]  wr_we;
  logic [9:0]  wr_addr;
  logic [31:0] wr_din;
  logic        rd_en;
  logic [9:0]  rd_addr;
  logic [31:0] dout_wf, dout_rf;
  logic        valid_wf, valid_rf;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  jelly2_ram_sdp_byteen #(
    .ADDR_WIDTH (10), .WE_WIDTH (4), .WORD_WIDTH (8), .MEM_SIZE (1000),
    .DOUT_REGS (1), .RDW_MODE ("WRITE_FIRST")
  ) dut_wf (
    .clk (clk), .reset_n (reset_n), .cke (cke),
    .wr_en (wr_en), .wr_we (wr_we), .wr_addr (wr_addr), .wr_din (wr_din),
    .rd_en (rd_en), .rd_addr (rd_addr), .rd_dout (dout_wf), .rd_valid (valid_wf)
  );

  jelly2_ram_sdp_byteen #(
    .ADDR_WIDTH (10), .WE_WIDTH (4), .WORD_WIDTH (8), .MEM_SIZE (1000),
    .DOUT_REGS (1), .RDW_MODE ("READ_FIRST")
  ) dut_rf (
    .clk (clk), .reset_n (reset_n), .cke (cke),
    .wr_en (wr_en), .wr_we (wr_we), .wr_addr (wr_addr), .wr_din (wr_din),
    .rd_en (rd_en), .rd_addr (rd_addr), .rd_dout (dout_rf), .rd_valid (valid_rf)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [9:0] a, input logic [31:0] d, input logic [3:0] we);
    wr_en = 1'b1; wr_addr = a; wr_din = d; wr_we = we;
    tick();
    wr_en = 1'b0; wr_we = 4'h0;
  endtask

  // Single read: valid observed after edges 1..3, data from both DUTs after edge 2.
  task automatic do_read(input logic [9:0] a, output logic v1, output logic v2, output logic v3,
                         output logic [31:0] d_wf, output logic [31:0] d_rf);
    rd_en = 1'b1; rd_addr = a;
    tick();
    rd_en = 1'b0;
    v1 = valid_wf | valid_rf;
    tick();
    v2 = valid_wf & valid_rf; d_wf = dout_wf; d_rf = dout_rf;
    tick();
    v3 = valid_wf | valid_rf;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; cke = 1'b1; wr_en = 1'b0; wr_we = 4'h0; wr_addr = '0; wr_din = '0;
    rd_en = 1'b0; rd_addr = '0;
    tick(); tick();
    checks++; if (dout_wf !== 32'h0 || valid_wf !== 1'b0) begin
      errors++; $display("FAIL reset_wf got dout=%h valid=%b want 00000000/0", dout_wf, valid_wf);
    end
    checks++; if (dout_rf !== 32'h0 || valid_rf !== 1'b0) begin
      errors++; $display("FAIL reset_rf got dout=%h valid=%b want 00000000/0", dout_rf, valid_rf);
    end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_write_read();
    logic v1, v2, v3; logic [31:0] dw, dr;
    do_write(10'd5, 32'h11223344, 4'hF);
    do_read(10'd5, v1, v2, v3, dw, dr);
    checks++; if (v1 !== 1'b0 || v2 !== 1'b1 || v3 !== 1'b0) begin
      errors++; $display("FAIL latency got valid e1..e3=%b%b%b want 010", v1, v2, v3);
    end
    checks++; if (dw !== 32'h11223344) begin
      errors++; $display("FAIL full_write_wf got %h want 11223344", dw);
    end
    checks++; if (dr !== 32'h11223344) begin
      errors++; $display("FAIL full_write_rf got %h want 11223344", dr);
    end
  endtask

  task automatic test_byte_enable();
    logic v1, v2, v3; logic [31:0] dw, dr;
    do_write(10'd5, 32'hAABBCCDD, 4'h5);
    do_read(10'd5, v1, v2, v3, dw, dr);
    checks++; if (dw !== 32'h11BB33DD || dr !== 32'h11BB33DD || v2 !== 1'b1) begin
      errors++; $display("FAIL byte_enable got wf=%h rf=%h valid=%b want 11BB33DD/1", dw, dr, v2);
    end
    do_write(10'd5, 32'hFFFFFFFF, 4'h0);
    do_read(10'd5, v1, v2, v3, dw, dr);
    checks++; if (dw !== 32'h11BB33DD) begin
      errors++; $display("FAIL we_zero_noop got %h want 11BB33DD", dw);
    end
  endtask

  task automatic test_rdw();
    do_write(10'd7, 32'h01020304, 4'hF);
    wr_en = 1'b1; wr_addr = 10'd7; wr_din = 32'hDEADBEEF; wr_we = 4'h3;
    rd_en = 1'b1; rd_addr = 10'd7;
    tick();
    wr_en = 1'b0; wr_we = 4'h0;
    tick();
    rd_en = 1'b0;
    checks++; if (dout_wf !== 32'h0102BEEF || valid_wf !== 1'b1) begin
      errors++; $display("FAIL rdw_write_first got %h valid=%b want 0102BEEF/1", dout_wf, valid_wf);
    end
    checks++; if (dout_rf !== 32'h01020304 || valid_rf !== 1'b1) begin
      errors++; $display("FAIL rdw_read_first got %h valid=%b want 01020304/1", dout_rf, valid_rf);
    end
    tick();
    checks++; if (dout_wf !== 32'h0102BEEF || dout_rf !== 32'h0102BEEF) begin
      errors++; $display("FAIL rdw_next_cycle got wf=%h rf=%h want 0102BEEF", dout_wf, dout_rf);
    end
    tick();
  endtask

  task automatic test_stall();
    logic        t_cke [9]  = '{1, 1, 0, 0, 0, 1, 1, 1, 1};
    logic        t_ren [9]  = '{1, 1, 1, 1, 1, 1, 1, 0, 0};
    logic [9:0]  t_addr [9] = '{10, 11, 12, 12, 12, 12, 13, 0, 0};
    logic        e_vld [9]  = '{0, 1, 1, 1, 1, 1, 1, 1, 0};
    logic [31:0] e_dout [9] = '{32'h0102BEEF, 32'h10101010, 32'h10101010, 32'h10101010,
                                32'h10101010, 32'h11111111, 32'h12121212, 32'h13131313,
                                32'h13131313};
    int pulses = 0;
    do_write(10'd10, 32'h10101010, 4'hF);
    do_write(10'd11, 32'h11111111, 4'hF);
    do_write(10'd12, 32'h12121212, 4'hF);
    do_write(10'd13, 32'h13131313, 4'hF);
    for (int c = 0; c < 9; c++) begin
      cke = t_cke[c]; rd_en = t_ren[c]; rd_addr = t_addr[c];
      // A write attempted while stalled must not land.
      wr_en = (c == 3); wr_addr = 10'd13; wr_din = 32'hFFFFFFFF; wr_we = 4'hF;
      tick();
      if (t_cke[c] && valid_wf) pulses++;
      checks++; if (valid_wf !== e_vld[c] || dout_wf !== e_dout[c]) begin
        errors++; $display("FAIL stall_cyc%0d got %h/%b want %h/%b",
                           c, dout_wf, valid_wf, e_dout[c], e_vld[c]);
      end
    end
    wr_en = 1'b0; wr_we = 4'h0; rd_en = 1'b0; cke = 1'b1;
    checks++; if (pulses != 4) begin
      errors++; $display("FAIL stall_pulses got %0d want 4", pulses);
    end
  endtask

  task automatic test_reset_midflight();
    logic v1, v2, v3; logic [31:0] dw, dr;
    logic saw_valid;
    do_write(10'd1, 32'hA1A1A1A1, 4'hF);
    do_write(10'd2, 32'hB2B2B2B2, 4'hF);
    rd_en = 1'b1; rd_addr = 10'd1;
    tick();
    rd_addr = 10'd2;
    tick();
    rd_en = 1'b0;
    checks++; if (valid_wf !== 1'b1 || dout_wf !== 32'hA1A1A1A1) begin
      errors++; $display("FAIL pre_reset got %h/%b want A1A1A1A1/1", dout_wf, valid_wf);
    end
    #1 reset_n = 1'b0;
    #1;
    checks++; if (valid_wf !== 1'b0 || dout_wf !== 32'h0 || valid_rf !== 1'b0 || dout_rf !== 32'h0) begin
      errors++; $display("FAIL async_reset got wf=%h/%b rf=%h/%b want 0/0",
                         dout_wf, valid_wf, dout_rf, valid_rf);
    end
    tick();
    reset_n = 1'b1;
    saw_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (valid_wf || valid_rf) saw_valid = 1'b1;
    end
    checks++; if (saw_valid !== 1'b0 || dout_wf !== 32'h0) begin
      errors++; $display("FAIL reset_drop got valid_seen=%b dout=%h want 0/00000000", saw_valid, dout_wf);
    end
    do_read(10'd2, v1, v2, v3, dw, dr);
    checks++; if (dw !== 32'hB2B2B2B2 || dr !== 32'hB2B2B2B2 || v2 !== 1'b1) begin
      errors++; $display("FAIL mem_retained got wf=%h rf=%h valid=%b want B2B2B2B2/1", dw, dr, v2);
    end
  endtask

  task automatic test_out_of_range();
    logic v1, v2, v3; logic [31:0] dw, dr;
    do_write(10'd999, 32'hCAFEF00D, 4'hF);
    do_write(10'd1010, 32'h55555555, 4'hF);
    do_read(10'd1010, v1, v2, v3, dw, dr);
    checks++; if (dw !== 32'h0 || dr !== 32'h0 || v2 !== 1'b1) begin
      errors++; $display("FAIL oor_read got wf=%h rf=%h valid=%b want 00000000/1", dw, dr, v2);
    end
    do_read(10'd999, v1, v2, v3, dw, dr);
    checks++; if (dw !== 32'hCAFEF00D) begin
      errors++; $display("FAIL oor_neighbour got %h want CAFEF00D", dw);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_enable();
    test_rdw();
    test_stall();
    test_reset_midflight();
    test_out_of_range();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
